// File: rtl/down_counter4.sv
// Loadable down-counter with borrow out, zero flag and sticky done flag.
// On underflow it either wraps to all-ones or reloads the last loaded value.
module down_counter4 #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic             CE,
  input  logic             RELOAD,
  output logic [WIDTH-1:0] O,
  output logic             BOUT,
  output logic             ZERO,
  output logic             DONE
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rld_q, rld_d;
  logic             done_q, done_d;
  logic             is_zero;

  assign is_zero = (cnt_q == '0);

  always_comb begin
    cnt_d  = cnt_q;
    rld_d  = rld_q;
    done_d = done_q;
    if (LOAD) begin
      cnt_d  = D;
      rld_d  = D;
      done_d = 1'b0;
    end else if (CE) begin
      if (!is_zero) begin
        cnt_d = cnt_q - ONE;
      end else begin
        // Borrow: RELOAD only matters here.
        cnt_d  = RELOAD ? rld_q : '1;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      cnt_q  <= '0;
      rld_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rld_q  <= rld_d;
      done_q <= done_d;
    end
  end

  assign O    = cnt_q;
  assign ZERO = is_zero;
  assign BOUT = CE & ~LOAD & is_zero;
  assign DONE = done_q;

endmodule

// File: tb/tb_down_counter4.sv
// Scoreboard bench for down_counter4: a driver pushes per-cycle expectations from
// an arithmetic model, a monitor pops and compares them at each falling edge.
module tb_down_counter4;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rstn_s = 1'b0;
  logic         load_s = 1'b0;
  logic [W-1:0] d_s = '0;
  logic         ce_s = 1'b0;
  logic         rel_s = 1'b0;
  logic [W-1:0] o_w;
  logic         bout_w, zero_w, done_w;

  down_counter4 #(.WIDTH(W)) dut (
    .CLK(clk), .RESETN(rstn_s), .LOAD(load_s), .D(d_s), .CE(ce_s),
    .RELOAD(rel_s), .O(o_w), .BOUT(bout_w), .ZERO(zero_w), .DONE(done_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    int o;
    bit bout;
    bit zero;
    bit done;
    int cyc;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Model state: count, reload value, sticky done.
  int m_cnt = 0;
  int m_rld = 0;
  bit m_done = 1'b0;

  task automatic model_reset();
    m_cnt = 0;
    m_rld = 0;
    m_done = 1'b0;
  endtask

  task automatic model_step(input bit load, input int d, input bit ce, input bit rel);
    if (load) begin
      m_cnt = d;
      m_rld = d;
      m_done = 1'b0;
    end else if (ce) begin
      if (m_cnt != 0) begin
        m_cnt = (m_cnt + MOD - 1) % MOD;
      end else begin
        m_cnt = rel ? m_rld : MOD - 1;
        m_done = 1'b1;
      end
    end
  endtask

  // rstn=0 holds reset through the next edge; pulse=1 drops reset only briefly
  // between edges so the following edge already updates.
  task automatic step(input bit rstn, input bit pulse, input bit load, input int d,
                      input bit ce, input bit rel);
    exp_t e;
    @(posedge clk);
    #1;
    load_s = load;
    d_s    = W'(d);
    ce_s   = ce;
    rel_s  = rel;
    if (!rstn || pulse) begin
      rstn_s = 1'b0;
      model_reset();
    end else begin
      rstn_s = 1'b1;
    end
    e.o    = m_cnt;
    e.zero = (m_cnt == 0);
    e.bout = ce && !load && (m_cnt == 0);
    e.done = m_done;
    e.cyc  = cyc;
    q.push_back(e);
    cyc++;
    if (pulse) begin
      fork
        begin
          #6;
          rstn_s = 1'b1;
        end
      join_none
    end
    if (rstn) model_step(load, d, ce, rel);
  endtask

  task automatic check(input string name, input int got, input int want, input int c);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", name, c, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("O",    int'(o_w),    e.o,        e.cyc);
        check("ZERO", int'(zero_w), int'(e.zero), e.cyc);
        check("BOUT", int'(bout_w), int'(e.bout), e.cyc);
        check("DONE", int'(done_w), int'(e.done), e.cyc);
      end
    end
  end

  initial begin : driver
    int ce_pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    // Reset held, then CE asserted during reset, then release with one borrow.
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    // Countdown with reload.
    step(1, 0, 1, 3, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 1, 1);
    // Wrap mode.
    step(1, 0, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1, 0);
    // LOAD beats CE at zero; later reload restores 9.
    step(1, 0, 1, 0, 0, 1);
    step(1, 0, 1, 9, 1, 1);
    for (int i = 0; i < 11; i++) step(1, 0, 0, 0, 1, 1);
    // CE gaps.
    step(1, 0, 1, 2, 0, 1);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, ce_pat[i] != 0, 1);
    step(1, 0, 0, 0, 0, 1);
    // Mid-count reset, then reload shows R was cleared.
    step(1, 0, 1, 12, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1, 1);
    step(1, 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 1);
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(1, $urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0,
           int'($urandom_range(0, MOD - 1)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1);
    end
    step(1, 0, 0, 0, 0, 0);
    begin
      int waited = 0;
      while (q.size() > 0 && waited < 10) begin
        @(posedge clk);
        waited++;
      end
      if (q.size() > 0) begin
        total++;
        bad++;
        $display("FAIL drain got=%0d want=0", q.size());
      end
    end
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "timeout");
  end

endmodule
